// File: rtl/cdb_arbiter_pkg.sv
// Shared types, sizes and the ROB age compare for the CDB writeback path.
package cdb_arbiter_pkg;

    localparam int N_SRC  = 3;
    localparam int QDEPTH = 2;
    localparam int DATA_W = 32;
    localparam int PREG_W = 7;
    localparam int ROB_W  = 4;
    localparam int CNT_W  = $clog2(QDEPTH + 1);

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_BR  = 2'd1;
    localparam logic [1:0] FU_LSU = 2'd2;

    // One writeback result; also used as a skid-queue entry (valid = slot occupied)
    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob_tag;
        logic [1:0]        src;
    } cdb_data_t;

    // True when 'tag' is younger than 'ref_tag', ages measured from the ROB head
    // with wrap; the reference tag itself is never younger than itself.
    function automatic logic rob_younger(input logic [ROB_W-1:0] tag,
                                         input logic [ROB_W-1:0] ref_tag,
                                         input logic [ROB_W-1:0] head);
        logic [ROB_W-1:0] age_tag;
        logic [ROB_W-1:0] age_ref;
        age_tag = tag - head;
        age_ref = ref_tag - head;
        return age_tag > age_ref;
    endfunction

endpackage

// File: rtl/cdb_src_queue.sv
// Per-FU skid queue: compacted FIFO with per-entry valid bits. In one cycle the
// update order is squash (drop younger entries, close gaps), then pop, then push.
module cdb_src_queue
    import cdb_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  cdb_data_t        push_entry,
    input  logic             pop,
    input  logic             mispredict,
    input  logic [ROB_W-1:0] mispredict_tag,
    input  logic [ROB_W-1:0] rob_head,
    output cdb_data_t        head,
    output logic [CNT_W-1:0] count
);

    cdb_data_t q      [QDEPTH];
    cdb_data_t q_next [QDEPTH];
    logic      placed;

    assign head = q[0];

    // Occupancy is the number of valid slots; slots are always packed at the head
    always_comb begin
        count = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            count = count + CNT_W'(q[i].valid);
        end
    end

    // Next-state: squash younger entries, compact, pop the head, append at tail
    always_comb begin
        placed = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            q_next[i] = q[i];
            if (mispredict && q[i].valid && rob_younger(q[i].rob_tag, mispredict_tag, rob_head)) begin
                q_next[i].valid = 1'b0;
            end
        end
        for (int p = 0; p < QDEPTH - 1; p++) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                if (!q_next[i].valid) begin
                    q_next[i]         = q_next[i+1];
                    q_next[i+1].valid = 1'b0;
                end
            end
        end
        if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                q_next[i] = q_next[i+1];
            end
            q_next[QDEPTH-1].valid = 1'b0;
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (push && !placed && !q_next[i].valid) begin
                q_next[i]       = push_entry;
                q_next[i].valid = 1'b1;
                placed          = 1'b1;
            end
        end
    end

    // Queue storage; reset empties every slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) q[i] <= q_next[i];
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus writeback scheduler: three FU skid queues, a round-robin pick
// of one surviving result per cycle, and a registered broadcast stage.
// Handshake: a source transfer happens on a rising edge where src_valid[i] &&
// src_ready[i]; a source holds its request until accepted. src_ready comes
// only from registered occupancy. The CDB side has no backpressure.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         src_valid,
    output logic [N_SRC-1:0]         src_ready,
    input  logic [N_SRC*PREG_W-1:0]  src_preg,
    input  logic [N_SRC*DATA_W-1:0]  src_data,
    input  logic [N_SRC*ROB_W-1:0]   src_rob_tag,
    input  logic                     mispredict,
    input  logic [ROB_W-1:0]         mispredict_tag,
    input  logic [ROB_W-1:0]         rob_head,
    output logic                     cdb_valid,
    output logic [PREG_W-1:0]        cdb_preg,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [ROB_W-1:0]         cdb_rob_tag,
    output logic [1:0]               cdb_src
);

    cdb_data_t        in_entry [N_SRC];
    cdb_data_t        q_head   [N_SRC];
    logic [CNT_W-1:0] q_count  [N_SRC];
    cdb_data_t        cand     [N_SRC];
    logic [N_SRC-1:0] cand_from_q, cand_live, accept, push, pop;
    logic [1:0]       rr_ptr, rr_idx, winner;
    logic             grant;
    cdb_data_t        win_entry;

    // Unpack the flat per-source request buses into entries
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            in_entry[i].valid   = src_valid[i];
            in_entry[i].preg    = src_preg[i*PREG_W +: PREG_W];
            in_entry[i].data    = src_data[i*DATA_W +: DATA_W];
            in_entry[i].rob_tag = src_rob_tag[i*ROB_W +: ROB_W];
            in_entry[i].src     = 2'(i);
        end
    end

    // Ready from registered count only; a full queue stays closed even while popping
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            src_ready[i] = (q_count[i] < CNT_W'(QDEPTH));
        end
    end

    // Per-source candidate: queue head if any, else the accepted incoming request
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            accept[i]      = src_valid[i] && src_ready[i];
            cand_from_q[i] = (q_count[i] != '0);
            cand[i]        = cand_from_q[i] ? q_head[i] : in_entry[i];
            cand_live[i]   = cand[i].valid && (cand_from_q[i] || src_ready[i]) &&
                             !(mispredict && rob_younger(cand[i].rob_tag, mispredict_tag, rob_head));
        end
    end

    // Round-robin search starting at rr_ptr, wrapping upward
    always_comb begin
        grant  = 1'b0;
        winner = rr_ptr;
        rr_idx = rr_ptr;
        for (int k = 0; k < N_SRC; k++) begin
            rr_idx = 2'((int'(rr_ptr) + k) % N_SRC);
            if (!grant && cand_live[rr_idx]) begin
                grant  = 1'b1;
                winner = rr_idx;
            end
        end
        win_entry = cand[winner];
    end

    // Queue controls: pop a winning head; enqueue accepted requests that did not
    // bypass straight to the bus and are not being squashed this cycle
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            pop[i]  = grant && (winner == 2'(i)) && cand_from_q[i];
            push[i] = accept[i] &&
                      !(grant && (winner == 2'(i)) && !cand_from_q[i]) &&
                      !(mispredict && rob_younger(in_entry[i].rob_tag, mispredict_tag, rob_head));
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_queue
        cdb_src_queue u_queue (
            .clk            (clk),
            .reset          (reset),
            .push           (push[g]),
            .push_entry     (in_entry[g]),
            .pop            (pop[g]),
            .mispredict     (mispredict),
            .mispredict_tag (mispredict_tag),
            .rob_head       (rob_head),
            .head           (q_head[g]),
            .count          (q_count[g])
        );
    end

    // Broadcast register and round-robin pointer; payload holds when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid   <= 1'b0;
            cdb_preg    <= '0;
            cdb_data    <= '0;
            cdb_rob_tag <= '0;
            cdb_src     <= '0;
            rr_ptr      <= '0;
        end else begin
            cdb_valid <= grant;
            if (grant) begin
                cdb_preg    <= win_entry.preg;
                cdb_data    <= win_entry.data;
                cdb_rob_tag <= win_entry.rob_tag;
                cdb_src     <= win_entry.src;
                rr_ptr      <= (winner == 2'(N_SRC - 1)) ? 2'd0 : winner + 2'd1;
            end
        end
    end

endmodule
